acc_rd_addr_gen: RTL and testbench

// Parametrised accumulator read-address sequencer. Generates per-column read

---
 rtl/acc_rd_addr_gen.sv | 147 ++++++++++++++
 tb/tb_acc_rd_addr_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_rd_addr_gen.sv
// Accumulator read-address sequencer: per-column read enables/addresses, NORMAL or DIAG (de-skew) order.
// Optional ACC_RD_STRIDE_EN adds stride_i (row stride latched at start); otherwise the stride is 1.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads, t advances on unstalled cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module acc_rd_addr_gen #(
    parameter int N_COLS = 32,
    parameter int ADDR_W = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [ADDR_W:0]            n_rows_i,
`ifdef ACC_RD_STRIDE_EN
    input  logic [ADDR_W-1:0]          stride_i,
`endif
    input  logic                       stall_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [N_COLS-1:0]          rd_en_o,
    output logic [N_COLS*ADDR_W-1:0]   rd_addr_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int T_W   = $clog2(DEPTH + N_COLS);
    localparam logic MODE_NORMAL = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [T_W-1:0]      t_q, t_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     n_rows_q, n_rows_d;
    logic [ADDR_W-1:0]   stride_s;
    logic [T_W-1:0]      t_last;
    logic                col_act;
    logic [ADDR_W-1:0]   col_off;

`ifdef ACC_RD_STRIDE_EN
    logic [ADDR_W-1:0]   stride_q, stride_d;
    assign stride_s = stride_q;
`else
    assign stride_s = ADDR_W'(1);
`endif

    // DIAG runs N_COLS-1 extra cycles so the last column can drain
    assign t_last = (mode_q == MODE_NORMAL) ? (T_W'(n_rows_q) - T_W'(1))
                                            : (T_W'(n_rows_q) + T_W'(N_COLS - 2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            mode_q   <= 1'b0;
            base_q   <= '0;
            n_rows_q <= '0;
`ifdef ACC_RD_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            n_rows_q <= n_rows_d;
`ifdef ACC_RD_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        mode_d   = mode_q;
        base_d   = base_q;
        n_rows_d = n_rows_q;
`ifdef ACC_RD_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    base_d   = base_addr_i;
                    n_rows_d = n_rows_i;
`ifdef ACC_RD_STRIDE_EN
                    stride_d = stride_i;
`endif
                    t_d      = '0;
                    state_d  = (n_rows_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!stall_i) begin
                    if (t_q == t_last) begin
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

    // Addresses come from registered state only; stall_i gates just the enables
    always_comb begin
        rd_en_o   = '0;
        rd_addr_o = '0;
        col_act   = 1'b0;
        col_off   = '0;
        if (state_q == S_RUN) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (mode_q == MODE_NORMAL) begin
                    col_act = 1'b1;
                    col_off = ADDR_W'(t_q);
                end else begin
                    col_act = (t_q >= T_W'(c)) && (t_q < (T_W'(c) + T_W'(n_rows_q)));
                    col_off = ADDR_W'(t_q - T_W'(c));
                end
                if (col_act) begin
                    rd_en_o[c]                     = !stall_i;
                    rd_addr_o[c*ADDR_W +: ADDR_W]  = base_q + col_off * stride_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_rd_addr_gen.sv
// Scoreboard bench for acc_rd_addr_gen: stimulus pushes expected read beats, a negedge monitor pops and compares.
module tb_acc_rd_addr_gen;

    localparam int N_COLS = 32;
    localparam int ADDR_W = 7;
    localparam int AW_T   = N_COLS * ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic                 mode_i = 1'b0;
    logic [ADDR_W-1:0]    base_addr_i = '0;
    logic [ADDR_W:0]      n_rows_i = '0;
    logic [ADDR_W-1:0]    stride_i = 7'd1;
    logic                 stall_i = 1'b0;
    logic                 busy_o;
    logic                 done_o;
    logic [N_COLS-1:0]    rd_en_o;
    logic [AW_T-1:0]      rd_addr_o;

    acc_rd_addr_gen #(.N_COLS(N_COLS), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .mode_i(mode_i),
        .base_addr_i(base_addr_i),
        .n_rows_i(n_rows_i),
`ifdef ACC_RD_STRIDE_EN
        .stride_i(stride_i),
`endif
        .stall_i(stall_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .rd_en_o(rd_en_o),
        .rd_addr_o(rd_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              done;
        logic [N_COLS-1:0] en;
        logic [AW_T-1:0]   addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en_o != '0 || done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got en=%0h done=%0b required no output", rd_en_o, done_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_en", 256'(rd_en_o), 256'(mon_e.en));
                check("sb_addr", 256'(rd_addr_o), 256'(mon_e.addr));
                check("sb_done", 256'(done_o), 256'(mon_e.done));
            end
        end
    end

    task automatic push_seq(input logic m, input int base, input int n, input int s);
        exp_t e;
        int   last;
        bit   act;
        if (n > 0) begin
            last = m ? (n + N_COLS - 2) : (n - 1);
            for (int k = 0; k <= last; k++) begin
                e = '0;
                for (int c = 0; c < N_COLS; c++) begin
                    act = m ? (c <= k && k < c + n) : 1'b1;
                    if (act) begin
                        e.en[c] = 1'b1;
                        e.addr[c*ADDR_W +: ADDR_W] = ADDR_W'(base + (m ? (k - c) : k) * s);
                    end
                end
                exp_q.push_back(e);
            end
        end
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic start_seq(input logic m, input int base, input int n, input int s);
        int s_eff;
`ifdef ACC_RD_STRIDE_EN
        s_eff = s;
`else
        s_eff = 1;
`endif
        mode_i      = m;
        base_addr_i = ADDR_W'(base);
        n_rows_i    = (ADDR_W+1)'(n);
        stride_i    = ADDR_W'(s);
        start_i     = 1'b1;
        push_seq(m, base, n, s_eff);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done_o) seen = 1'b1;
        end
        check(name, 256'(cyc), 256'(exp_cyc));
        @(posedge clk);
        #1;
        check({name, "_q_empty"}, 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 256'(busy_o), 256'd0);
        check("rst_done", 256'(done_o), 256'd0);
        check("rst_en", 256'(rd_en_o), 256'd0);
        check("rst_addr", 256'(rd_addr_o), 256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // NORMAL base 5, four rows
        start_seq(1'b0, 5, 4, 1);
        wait_done("normal_lat", 5);

        // DIAG full de-skew
        start_seq(1'b1, 0, 32, 1);
        @(negedge clk);
        check("diag_t0_en", 256'(rd_en_o), 256'h1);
        check("diag_t0_addr", 256'(rd_addr_o), 256'd0);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("diag_t31_en", 256'(rd_en_o), 256'hffff_ffff);
        check("diag_t31_c0", 256'(rd_addr_o[0 +: ADDR_W]), 256'd31);
        check("diag_t31_c5", 256'(rd_addr_o[5*ADDR_W +: ADDR_W]), 256'd26);
        check("diag_t31_c31", 256'(rd_addr_o[31*ADDR_W +: ADDR_W]), 256'd0);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("diag_t62_en", 256'(rd_en_o), 256'h8000_0000);
        check("diag_t62_c31", 256'(rd_addr_o[31*ADDR_W +: ADDR_W]), 256'd31);
        check("diag_t62_c0", 256'(rd_addr_o[0 +: ADDR_W]), 256'd0);
        wait_done("diag_lat", 1);

        // address wrap
        start_seq(1'b0, 126, 4, 1);
        wait_done("wrap_lat", 5);

        // two stalled cycles at t=1
        start_seq(1'b0, 0, 3, 1);
        @(posedge clk);
        #1;
        stall_i = 1'b1;
        @(negedge clk);
        check("stall1_en", 256'(rd_en_o), 256'd0);
        check("stall1_c0", 256'(rd_addr_o[0 +: ADDR_W]), 256'd1);
        check("stall1_c31", 256'(rd_addr_o[31*ADDR_W +: ADDR_W]), 256'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall2_en", 256'(rd_en_o), 256'd0);
        check("stall2_c0", 256'(rd_addr_o[0 +: ADDR_W]), 256'd1);
        check("stall2_busy", 256'(busy_o), 256'd1);
        @(posedge clk);
        #1;
        stall_i = 1'b0;
        wait_done("stall_lat", 3);

        // start while busy is ignored
        start_seq(1'b0, 10, 4, 1);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        mode_i      = 1'b1;
        base_addr_i = 7'd50;
        n_rows_i    = 8'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("busy_ign_lat", 3);

        // zero rows goes straight to DONE
        start_seq(1'b0, 3, 0, 1);
        wait_done("zero_lat", 1);

        // reset mid DIAG at t=10
        start_seq(1'b1, 0, 32, 1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_busy", 256'(busy_o), 256'd0);
        check("mrst_en", 256'(rd_en_o), 256'd0);
        check("mrst_addr", 256'(rd_addr_o), 256'd0);
        check("mrst_done", 256'(done_o), 256'd0);
        @(posedge clk);
        #1;
        start_seq(1'b0, 1, 2, 1);
        wait_done("post_rst_lat", 3);

`ifdef ACC_RD_STRIDE_EN
        start_seq(1'b0, 0, 4, 3);
        wait_done("stride3_lat", 5);
        start_seq(1'b0, 9, 3, 0);
        wait_done("stride0_lat", 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
